// File: rtl/count_check_pkg.sv
// count_check_pkg: shared types, widths and defaults for the count_checker slice.
package count_check_pkg;

    typedef enum logic [1:0] {
        ST_CAPTURE,
        ST_ACQUIRE,
        ST_LOCKED
    } check_state_t;

    localparam int ERR_CNT_W       = 16;
    localparam int WRAP_CNT_W      = 8;
    localparam int STEP_CNT_W      = 4;
    localparam int DEF_WIDTH       = 4;
    localparam int DEF_SYNC_CYCLES = 2;
    localparam int DEF_ERR_LIMIT   = 3;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/count_step_check.sv
// count_step_check: combinational check that one channel moved by DIR (or held when en=0).
module count_step_check #(
    parameter int WIDTH = 4,
    parameter int DIR   = 1
) (
    input  logic [WIDTH-1:0] prev,
    input  logic [WIDTH-1:0] obs,
    input  logic             en,
    output logic             ok
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(DIR);

    assign ok = obs == (en ? prev + STEP : prev);

endmodule

// File: rtl/count_checker.sv
// count_checker: lock-and-track monitor for the top_counter up/down channels.
// Optional wrap_count port and counter under COUNT_CHECK_WRAP_EN.
module count_checker import count_check_pkg::*; #(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SYNC_CYCLES = DEF_SYNC_CYCLES,
    parameter int ERR_LIMIT   = DEF_ERR_LIMIT
) (
    input  logic                  refclk,
    input  logic                  reset_n,
    input  logic                  count_en,
    input  logic [WIDTH-1:0]      count_up,
    input  logic [WIDTH-1:0]      count_down,
    output logic                  locked,
    output logic                  step_err,
`ifdef COUNT_CHECK_WRAP_EN
    output logic [WRAP_CNT_W-1:0] wrap_count,
`endif
    output logic [ERR_CNT_W-1:0]  err_count
);

    localparam logic [STEP_CNT_W-1:0] SYNC_N = STEP_CNT_W'(SYNC_CYCLES);
    localparam logic [STEP_CNT_W-1:0] ERR_N  = STEP_CNT_W'(ERR_LIMIT);

    check_state_t          state_q, state_d;
    logic [WIDTH-1:0]      prev_up_q, prev_down_q;
    logic [STEP_CNT_W-1:0] good_cnt_q, good_cnt_d, bad_cnt_q, bad_cnt_d;
    logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;
    logic                  locked_q, step_err_q, step_err_d;
    logic                  up_ok, down_ok, good;
    logic [STEP_CNT_W-1:0] good_inc, bad_inc;

    count_step_check #(.WIDTH(WIDTH), .DIR(1)) u_up (
        .prev(prev_up_q), .obs(count_up), .en(count_en), .ok(up_ok)
    );

    count_step_check #(.WIDTH(WIDTH), .DIR(-1)) u_down (
        .prev(prev_down_q), .obs(count_down), .en(count_en), .ok(down_ok)
    );

    assign good     = up_ok & down_ok;
    assign good_inc = good_cnt_q + STEP_CNT_W'(1);
    assign bad_inc  = bad_cnt_q + STEP_CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        good_cnt_d  = good_cnt_q;
        bad_cnt_d   = bad_cnt_q;
        step_err_d  = 1'b0;
        err_count_d = err_count_q;
        case (state_q)
            ST_CAPTURE: begin
                state_d    = ST_ACQUIRE;
                good_cnt_d = '0;
                bad_cnt_d  = '0;
            end
            ST_ACQUIRE: begin
                if (!good) begin
                    good_cnt_d = '0;
                end else if (good_inc == SYNC_N) begin
                    state_d    = ST_LOCKED;
                    good_cnt_d = '0;
                    bad_cnt_d  = '0;
                end else begin
                    good_cnt_d = good_inc;
                end
            end
            ST_LOCKED: begin
                if (good) begin
                    bad_cnt_d = '0;
                end else begin
                    step_err_d  = 1'b1;
                    err_count_d = sat_inc(err_count_q);
                    if (bad_inc == ERR_N) begin
                        state_d    = ST_ACQUIRE;
                        good_cnt_d = '0;
                        bad_cnt_d  = '0;
                    end else begin
                        bad_cnt_d = bad_inc;
                    end
                end
            end
            default: state_d = ST_CAPTURE;
        endcase
    end

    // prev registers follow the observed values unconditionally so the checker resyncs to reality
    always_ff @(posedge refclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_CAPTURE;
            prev_up_q   <= '0;
            prev_down_q <= '0;
            good_cnt_q  <= '0;
            bad_cnt_q   <= '0;
            err_count_q <= '0;
            locked_q    <= 1'b0;
            step_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_up_q   <= count_up;
            prev_down_q <= count_down;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            err_count_q <= err_count_d;
            locked_q    <= state_d == ST_LOCKED;
            step_err_q  <= step_err_d;
        end
    end

    assign locked    = locked_q;
    assign step_err  = step_err_q;
    assign err_count = err_count_q;

`ifdef COUNT_CHECK_WRAP_EN
    logic [WRAP_CNT_W-1:0] wrap_q;
    logic                  wrap_hit;

    assign wrap_hit = (state_q == ST_LOCKED) && count_en && (&prev_up_q) && (count_up == '0);

    always_ff @(posedge refclk or negedge reset_n) begin
        if (!reset_n) begin
            wrap_q <= '0;
        end else begin
            wrap_q <= wrap_q + WRAP_CNT_W'(wrap_hit);
        end
    end

    assign wrap_count = wrap_q;
`endif

endmodule
